// File: rtl/decode_stage_hs_pkg.sv
// Shared RV32I decode definitions: field extractors, immediate/ALU encodings
// and the bubble control word.
package decode_stage_hs_pkg;

  typedef enum logic [2:0] {EXT_I, EXT_S, EXT_B, EXT_U, EXT_J} ext_op_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_ctr_e;

  localparam logic [1:0] ALU2_REG  = 2'd0;
  localparam logic [1:0] ALU2_IMM  = 2'd1;
  localparam logic [1:0] ALU2_FOUR = 2'd2;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       alu1_src;
    logic [1:0] alu2_src;
    logic [3:0] alu_ctr;
    logic       mem_to_reg;
    logic       reg_wr_en;
    logic       mem_wr_en;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic [6:0] f_opcode(input logic [31:0] ins); return ins[6:0];   endfunction
  function automatic logic [4:0] f_rd    (input logic [31:0] ins); return ins[11:7];  endfunction
  function automatic logic [2:0] f_funct3(input logic [31:0] ins); return ins[14:12]; endfunction
  function automatic logic [4:0] f_rs1   (input logic [31:0] ins); return ins[19:15]; endfunction
  function automatic logic [4:0] f_rs2   (input logic [31:0] ins); return ins[24:20]; endfunction

  // alt selects SUB/SRA; callers gate it so addi with a negative immediate stays ADD
  function automatic logic [3:0] f_alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/controller.sv
// Main opcode decoder: produces the control word and immediate format.
module controller
  import decode_stage_hs_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output ctrl_t      ctrl,
  output ext_op_e    ext_op
);
  always_comb begin
    ctrl   = CTRL_BUBBLE;
    ext_op = EXT_I;
    case (opcode)
      OP_R: begin
        ctrl.reg_wr_en = 1'b1;
        ctrl.alu_ctr   = f_alu_decode(funct3, funct7_b5);
      end
      OP_I: begin
        ctrl.reg_wr_en = 1'b1;
        ctrl.alu2_src  = ALU2_IMM;
        ctrl.alu_ctr   = f_alu_decode(funct3, funct7_b5 && (funct3 == 3'b101));
      end
      OP_LOAD: begin
        ctrl.reg_wr_en  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu2_src   = ALU2_IMM;
      end
      OP_STORE: begin
        ctrl.mem_wr_en = 1'b1;
        ctrl.alu2_src  = ALU2_IMM;
        ext_op         = EXT_S;
      end
      OP_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.alu_ctr = ALU_SUB;
        ext_op       = EXT_B;
      end
      OP_JAL, OP_JALR: begin
        ctrl.jump      = 1'b1;
        ctrl.reg_wr_en = 1'b1;
        ctrl.alu1_src  = 1'b1;
        ctrl.alu2_src  = ALU2_FOUR;
        ext_op         = (opcode == OP_JAL) ? EXT_J : EXT_I;
      end
      OP_LUI: begin
        ctrl.reg_wr_en = 1'b1;
        ctrl.alu2_src  = ALU2_IMM;
        ctrl.alu_ctr   = ALU_PASSB;
        ext_op         = EXT_U;
      end
      OP_AUIPC: begin
        ctrl.reg_wr_en = 1'b1;
        ctrl.alu1_src  = 1'b1;
        ctrl.alu2_src  = ALU2_IMM;
        ext_op         = EXT_U;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/decode_hazard_unit.sv
// Load-use hazard detect, write-back bypass select and stalled-operand refresh match.
module decode_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic              out_valid,
  input  logic              out_mem_to_reg,
  input  logic [REG_AW-1:0] out_rd,
  input  logic [REG_AW-1:0] out_rs1,
  input  logic [REG_AW-1:0] out_rs2,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_dst,
  output logic              hazard,
  output logic              byp1,
  output logic              byp2,
  output logic              refresh1,
  output logic              refresh2
);
  logic wb_live;

  assign wb_live  = wb_en && (wb_dst != '0);
  // rs2 is compared even for formats that do not read it
  assign hazard   = out_valid && out_mem_to_reg && (out_rd != '0) &&
                    ((out_rd == rs1) || (out_rd == rs2));
  assign byp1     = BYPASS_WB && wb_live && (wb_dst == rs1);
  assign byp2     = BYPASS_WB && wb_live && (wb_dst == rs2);
  assign refresh1 = wb_live && (wb_dst == out_rs1);
  assign refresh2 = wb_live && (wb_dst == out_rs2);
endmodule

// File: rtl/imm_extend.sv
// Immediate assembly for the I/S/B/U/J formats, sign-extended to XLEN.
module imm_extend
  import decode_stage_hs_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  ext_op_e         ext_op,
  output logic [XLEN-1:0] imm
);
  logic [31:0] imm32;

  always_comb begin
    case (ext_op)
      EXT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      EXT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      EXT_U:   imm32 = {instr[31:12], 12'b0};
      EXT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file; x0 is hard-wired to zero.
module reg_file #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic [XLEN-1:0]   rd_data1,
  output logic [XLEN-1:0]   rd_data2
);
  logic [XLEN-1:0] regs [0:(1<<REG_AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr != '0)) regs[wr_addr] <= wr_data;
  end

  assign rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
endmodule

// File: rtl/decode_stage_hs.sv
// RV32I decode stage with valid/ready handshake; the output register is ID/EX.
module decode_stage_hs
  import decode_stage_hs_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int PC_W      = 32,
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [PC_W-1:0]   i_pipe_PC,
  input  logic [31:0]       i_pipe_Instruction,
  input  logic              i_flush,
  input  logic              i_RegWrEn,
  input  logic [REG_AW-1:0] i_RegDst,
  input  logic [XLEN-1:0]   i_RegWrData,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [PC_W-1:0]   o_pipe_PC,
  output logic [XLEN-1:0]   o_pipe_Imm,
  output logic [XLEN-1:0]   o_pipe_Reg1Data,
  output logic [XLEN-1:0]   o_pipe_Reg2Data,
  output logic [REG_AW-1:0] o_pipe_Reg1,
  output logic [REG_AW-1:0] o_pipe_Reg2,
  output logic [REG_AW-1:0] o_pipe_RegDst,
  output logic              o_pipe_Alu1Src,
  output logic [1:0]        o_pipe_Alu2Src,
  output logic [3:0]        o_pipe_AluCtr,
  output logic              o_pipe_MemToReg,
  output logic              o_pipe_RegWrEn,
  output logic              o_pipe_MemWrEn,
  output logic              o_pipe_Branch,
  output logic              o_pipe_Jump
);
  logic [REG_AW-1:0] rs1, rs2, rd;
  ctrl_t             ctrl_dec;
  ext_op_e           ext_op;
  logic [XLEN-1:0]   imm, rf_data1, rf_data2, read1, read2;
  logic              adv, hazard, byp1, byp2, refresh1, refresh2;

  logic              valid_reg;
  ctrl_t             ctrl_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [XLEN-1:0]   imm_reg, reg1_data_reg, reg2_data_reg;
  logic [REG_AW-1:0] reg1_reg, reg2_reg, reg_dst_reg;

  assign rs1 = REG_AW'(f_rs1(i_pipe_Instruction));
  assign rs2 = REG_AW'(f_rs2(i_pipe_Instruction));
  assign rd  = REG_AW'(f_rd(i_pipe_Instruction));

  controller u_ctrl (
    .opcode    (f_opcode(i_pipe_Instruction)),
    .funct3    (f_funct3(i_pipe_Instruction)),
    .funct7_b5 (i_pipe_Instruction[30]),
    .ctrl      (ctrl_dec),
    .ext_op    (ext_op)
  );

  imm_extend #(.XLEN(XLEN)) u_imm (
    .instr  (i_pipe_Instruction[31:7]),
    .ext_op (ext_op),
    .imm    (imm)
  );

  reg_file #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rf (
    .clk      (clk),
    .wr_en    (i_RegWrEn),
    .wr_addr  (i_RegDst),
    .wr_data  (i_RegWrData),
    .rd_addr1 (rs1),
    .rd_addr2 (rs2),
    .rd_data1 (rf_data1),
    .rd_data2 (rf_data2)
  );

  decode_hazard_unit #(.REG_AW(REG_AW), .BYPASS_WB(BYPASS_WB)) u_haz (
    .out_valid      (valid_reg),
    .out_mem_to_reg (ctrl_reg.mem_to_reg),
    .out_rd         (reg_dst_reg),
    .out_rs1        (reg1_reg),
    .out_rs2        (reg2_reg),
    .rs1            (rs1),
    .rs2            (rs2),
    .wb_en          (i_RegWrEn),
    .wb_dst         (i_RegDst),
    .hazard         (hazard),
    .byp1           (byp1),
    .byp2           (byp2),
    .refresh1       (refresh1),
    .refresh2       (refresh2)
  );

  assign read1   = byp1 ? i_RegWrData : rf_data1;
  assign read2   = byp2 ? i_RegWrData : rf_data2;
  assign adv     = !valid_reg || i_ready;
  assign o_ready = i_flush || (adv && !hazard);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg     <= 1'b0;
      ctrl_reg      <= CTRL_BUBBLE;
      pc_reg        <= '0;
      imm_reg       <= '0;
      reg1_data_reg <= '0;
      reg2_data_reg <= '0;
      reg1_reg      <= '0;
      reg2_reg      <= '0;
      reg_dst_reg   <= '0;
    end else if (i_flush) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= CTRL_BUBBLE;
    end else if (adv) begin
      if (hazard) begin
        valid_reg <= 1'b0;
        ctrl_reg  <= CTRL_BUBBLE;
      end else begin
        valid_reg     <= i_valid;
        ctrl_reg      <= ctrl_dec;
        pc_reg        <= i_pipe_PC;
        imm_reg       <= imm;
        reg1_data_reg <= read1;
        reg2_data_reg <= read2;
        reg1_reg      <= rs1;
        reg2_reg      <= rs2;
        reg_dst_reg   <= rd;
      end
    end else begin
      // stalled: keep held operands in step with write-back
      if (refresh1) reg1_data_reg <= i_RegWrData;
      if (refresh2) reg2_data_reg <= i_RegWrData;
    end
  end

  assign o_valid         = valid_reg;
  assign o_pipe_PC       = pc_reg;
  assign o_pipe_Imm      = imm_reg;
  assign o_pipe_Reg1Data = reg1_data_reg;
  assign o_pipe_Reg2Data = reg2_data_reg;
  assign o_pipe_Reg1     = reg1_reg;
  assign o_pipe_Reg2     = reg2_reg;
  assign o_pipe_RegDst   = reg_dst_reg;
  assign o_pipe_Alu1Src  = ctrl_reg.alu1_src;
  assign o_pipe_Alu2Src  = ctrl_reg.alu2_src;
  assign o_pipe_AluCtr   = ctrl_reg.alu_ctr;
  assign o_pipe_MemToReg = ctrl_reg.mem_to_reg;
  assign o_pipe_RegWrEn  = ctrl_reg.reg_wr_en;
  assign o_pipe_MemWrEn  = ctrl_reg.mem_wr_en;
  assign o_pipe_Branch   = ctrl_reg.branch;
  assign o_pipe_Jump     = ctrl_reg.jump;
endmodule

// File: tb/tb_decode_stage_hs.sv
// Scoreboard bench for decode_stage_hs: directed RV32I vectors, monitor pops on each transfer.
module tb_decode_stage_hs;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        i_valid = 1'b0, i_ready = 1'b1, i_flush = 1'b0;
  logic [31:0] i_pipe_PC = '0, i_pipe_Instruction = '0;
  logic        i_RegWrEn = 1'b0;
  logic [4:0]  i_RegDst = '0;
  logic [31:0] i_RegWrData = '0;

  logic        o_ready, o_valid, o_pipe_Alu1Src, o_pipe_MemToReg, o_pipe_RegWrEn;
  logic        o_pipe_MemWrEn, o_pipe_Branch, o_pipe_Jump;
  logic [31:0] o_pipe_PC, o_pipe_Imm, o_pipe_Reg1Data, o_pipe_Reg2Data;
  logic [4:0]  o_pipe_Reg1, o_pipe_Reg2, o_pipe_RegDst;
  logic [1:0]  o_pipe_Alu2Src;
  logic [3:0]  o_pipe_AluCtr;

  logic        nb_ready, nb_valid, nb_alu1, nb_m2r, nb_rwe, nb_mwe, nb_br, nb_jmp;
  logic [31:0] nb_pc, nb_imm, nb_r1d, nb_r2d;
  logic [4:0]  nb_r1, nb_r2, nb_rd;
  logic [1:0]  nb_alu2;
  logic [3:0]  nb_aluctr;

  always #5 clk = ~clk;

  decode_stage_hs #(.XLEN(32), .REG_AW(5), .PC_W(32), .BYPASS_WB(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_pipe_PC(i_pipe_PC), .i_pipe_Instruction(i_pipe_Instruction), .i_flush(i_flush),
    .i_RegWrEn(i_RegWrEn), .i_RegDst(i_RegDst), .i_RegWrData(i_RegWrData),
    .o_valid(o_valid), .i_ready(i_ready), .o_pipe_PC(o_pipe_PC), .o_pipe_Imm(o_pipe_Imm),
    .o_pipe_Reg1Data(o_pipe_Reg1Data), .o_pipe_Reg2Data(o_pipe_Reg2Data),
    .o_pipe_Reg1(o_pipe_Reg1), .o_pipe_Reg2(o_pipe_Reg2), .o_pipe_RegDst(o_pipe_RegDst),
    .o_pipe_Alu1Src(o_pipe_Alu1Src), .o_pipe_Alu2Src(o_pipe_Alu2Src), .o_pipe_AluCtr(o_pipe_AluCtr),
    .o_pipe_MemToReg(o_pipe_MemToReg), .o_pipe_RegWrEn(o_pipe_RegWrEn),
    .o_pipe_MemWrEn(o_pipe_MemWrEn), .o_pipe_Branch(o_pipe_Branch), .o_pipe_Jump(o_pipe_Jump)
  );

  // Same stimulus, bypass disabled: used only for the stale-read check
  decode_stage_hs #(.XLEN(32), .REG_AW(5), .PC_W(32), .BYPASS_WB(1'b0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(nb_ready),
    .i_pipe_PC(i_pipe_PC), .i_pipe_Instruction(i_pipe_Instruction), .i_flush(i_flush),
    .i_RegWrEn(i_RegWrEn), .i_RegDst(i_RegDst), .i_RegWrData(i_RegWrData),
    .o_valid(nb_valid), .i_ready(i_ready), .o_pipe_PC(nb_pc), .o_pipe_Imm(nb_imm),
    .o_pipe_Reg1Data(nb_r1d), .o_pipe_Reg2Data(nb_r2d),
    .o_pipe_Reg1(nb_r1), .o_pipe_Reg2(nb_r2), .o_pipe_RegDst(nb_rd),
    .o_pipe_Alu1Src(nb_alu1), .o_pipe_Alu2Src(nb_alu2), .o_pipe_AluCtr(nb_aluctr),
    .o_pipe_MemToReg(nb_m2r), .o_pipe_RegWrEn(nb_rwe),
    .o_pipe_MemWrEn(nb_mwe), .o_pipe_Branch(nb_br), .o_pipe_Jump(nb_jmp)
  );

  localparam logic [31:0] ADDI_X1_5   = 32'h00500093;
  localparam logic [31:0] ADDI_X2_7   = 32'h00700113;
  localparam logic [31:0] LW_X3_X1    = 32'h0000A183;
  localparam logic [31:0] ADD_X4_X3X2 = 32'h00218233;
  localparam logic [31:0] ADD_X5_X6X7 = 32'h007302B3;
  localparam logic [31:0] ADD_X5_X0X7 = 32'h007002B3;
  localparam logic [31:0] ADDI_X11_M1 = 32'hFFF00593;
  localparam logic [31:0] SUB_X8_X9X10 = 32'h40A48433;

  typedef struct {
    logic [31:0] pc, imm, r1, r2;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  aluctr;
    logic        rwe, m2r;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, imm, input logic [4:0] rd, rs1, rs2,
                              input logic [31:0] r1, r2, input logic [3:0] aluctr,
                              input logic rwe, m2r);
    exp_t e;
    e.pc = pc; e.imm = imm; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.r1 = r1; e.r2 = r2; e.aluctr = aluctr; e.rwe = rwe; e.m2r = m2r;
    return e;
  endfunction

  // Monitor: a transfer to execute happens on the next edge when o_valid && i_ready
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output actual_pc=%h required=none", o_pipe_PC);
      end else begin
        e = sb.pop_front();
        $display("txn pc=%h rd=%0d r1=%h r2=%h imm=%h", o_pipe_PC, o_pipe_RegDst,
                 o_pipe_Reg1Data, o_pipe_Reg2Data, o_pipe_Imm);
        chk($sformatf("pc@%h", e.pc), o_pipe_PC, e.pc);
        chk($sformatf("imm@%h", e.pc), o_pipe_Imm, e.imm);
        chk($sformatf("rd@%h", e.pc), 32'(o_pipe_RegDst), 32'(e.rd));
        chk($sformatf("rs1@%h", e.pc), 32'(o_pipe_Reg1), 32'(e.rs1));
        chk($sformatf("rs2@%h", e.pc), 32'(o_pipe_Reg2), 32'(e.rs2));
        chk($sformatf("r1data@%h", e.pc), o_pipe_Reg1Data, e.r1);
        chk($sformatf("r2data@%h", e.pc), o_pipe_Reg2Data, e.r2);
        chk($sformatf("aluctr@%h", e.pc), 32'(o_pipe_AluCtr), 32'(e.aluctr));
        chk($sformatf("regwren@%h", e.pc), 32'(o_pipe_RegWrEn), 32'(e.rwe));
        chk($sformatf("memtoreg@%h", e.pc), 32'(o_pipe_MemToReg), 32'(e.m2r));
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    i_valid = 1'b1; i_pipe_Instruction = ins; i_pipe_PC = pc;
  endtask

  task automatic wb(input logic en, input logic [4:0] dst, input logic [31:0] data);
    i_RegWrEn = en; i_RegDst = dst; i_RegWrData = data;
  endtask

  task automatic chk_killed(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_enables"}, 32'({o_pipe_MemToReg, o_pipe_RegWrEn, o_pipe_MemWrEn,
                                o_pipe_Branch, o_pipe_Jump}), 0);
  endtask

  initial begin
    logic [4:0]  init_reg  [8] = '{5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd7, 5'd9, 5'd31};
    logic [31:0] init_data [8] = '{32'h100, 32'h200, 32'h300, 32'h5, 32'h11, 32'h77, 32'h99, 32'h31};

    step(); step();
    chk("reset_valid", 32'(o_valid), 0);
    chk("reset_pc", o_pipe_PC, 0);
    chk("reset_regwren", 32'(o_pipe_RegWrEn), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wb(1'b1, init_reg[i], init_data[i]);
      step();
    end
    wb(1'b0, 5'd0, 32'h0);
    chk("idle_valid", 32'(o_valid), 0);

    // Back-to-back stream
    drive(ADDI_X1_5, 32'h100); #1 chk("ready_addi1", 32'(o_ready), 1);
    sb.push_back(mk(32'h100, 32'h5, 5'd1, 5'd0, 5'd5, 32'h0, 32'h5, 4'd0, 1'b1, 1'b0));
    step();
    drive(ADDI_X2_7, 32'h104); #1 chk("ready_addi2", 32'(o_ready), 1);
    sb.push_back(mk(32'h104, 32'h7, 5'd2, 5'd0, 5'd7, 32'h0, 32'h77, 4'd0, 1'b1, 1'b0));
    step();

    // Load-use: one bubble
    drive(LW_X3_X1, 32'h108); #1 chk("ready_lw", 32'(o_ready), 1);
    sb.push_back(mk(32'h108, 32'h0, 5'd3, 5'd1, 5'd0, 32'h100, 32'h0, 4'd0, 1'b1, 1'b1));
    step();
    drive(ADD_X4_X3X2, 32'h10C); #1 chk("ready_hazard", 32'(o_ready), 0);
    step();
    chk_killed("bubble");
    #1 chk("ready_after_bubble", 32'(o_ready), 1);
    sb.push_back(mk(32'h10C, 32'h2, 5'd4, 5'd3, 5'd2, 32'h300, 32'h200, 4'd0, 1'b1, 1'b0));
    step();

    // Same-cycle write-back bypass
    drive(ADD_X5_X6X7, 32'h110); wb(1'b1, 5'd6, 32'hDEADBEEF);
    sb.push_back(mk(32'h110, 32'h7, 5'd5, 5'd6, 5'd7, 32'hDEADBEEF, 32'h77, 4'd0, 1'b1, 1'b0));
    step();
    chk("nobypass_stale_r1", nb_r1d, 32'h11);
    drive(ADD_X5_X0X7, 32'h114); wb(1'b1, 5'd0, 32'h1234);
    sb.push_back(mk(32'h114, 32'h7, 5'd5, 5'd0, 5'd7, 32'h0, 32'h77, 4'd0, 1'b1, 1'b0));
    step();
    wb(1'b0, 5'd0, 32'h0);
    drive(ADDI_X11_M1, 32'h118);
    sb.push_back(mk(32'h118, 32'hFFFFFFFF, 5'd11, 5'd0, 5'd31, 32'h0, 32'h31, 4'd0, 1'b1, 1'b0));
    step();
    i_valid = 1'b0; step();

    // Stall with operand refresh
    i_ready = 1'b0;
    drive(SUB_X8_X9X10, 32'h120); #1 chk("ready_sub", 32'(o_ready), 1);
    sb.push_back(mk(32'h120, 32'h40A, 5'd8, 5'd9, 5'd10, 32'h99, 32'h55, 4'd1, 1'b1, 1'b0));
    step();
    drive(ADDI_X1_5, 32'h124); wb(1'b1, 5'd10, 32'h55);
    #1 chk("ready_stall", 32'(o_ready), 0);
    step();
    wb(1'b0, 5'd0, 32'h0);
    chk("stall_r2data", o_pipe_Reg2Data, 32'h55);
    chk("stall_r1data", o_pipe_Reg1Data, 32'h99);
    chk("stall_pc", o_pipe_PC, 32'h120);
    chk("stall_valid", 32'(o_valid), 1);
    #1 chk("ready_stall2", 32'(o_ready), 0);
    i_ready = 1'b1;
    #1 chk("ready_release", 32'(o_ready), 1);
    sb.push_back(mk(32'h124, 32'h5, 5'd1, 5'd0, 5'd5, 32'h0, 32'h5, 4'd0, 1'b1, 1'b0));
    step();
    i_valid = 1'b0; step();

    // Flush during a stall
    i_ready = 1'b0;
    drive(ADDI_X2_7, 32'h130); step();
    drive(ADDI_X1_5, 32'h134); i_flush = 1'b1;
    #1 chk("ready_flush_stall", 32'(o_ready), 1);
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    chk_killed("flush_stall");
    i_ready = 1'b1;

    // Flush during a hazard
    drive(LW_X3_X1, 32'h140);
    sb.push_back(mk(32'h140, 32'h0, 5'd3, 5'd1, 5'd0, 32'h100, 32'h0, 4'd0, 1'b1, 1'b1));
    step();
    drive(ADD_X4_X3X2, 32'h144); i_flush = 1'b1;
    #1 chk("ready_flush_hazard", 32'(o_ready), 1);
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    chk_killed("flush_hazard");

    // Asynchronous reset mid-stall
    i_ready = 1'b0;
    drive(ADDI_X1_5, 32'h150); step();
    i_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(o_valid), 0);
    chk("async_rst_pc", o_pipe_PC, 0);
    chk("async_rst_imm", o_pipe_Imm, 0);
    chk("async_rst_rd", 32'(o_pipe_RegDst), 0);
    chk("async_rst_regwren", 32'(o_pipe_RegWrEn), 0);
    #2 reset_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(o_valid), 0);
    i_ready = 1'b1;
    drive(ADDI_X2_7, 32'h154);
    sb.push_back(mk(32'h154, 32'h7, 5'd2, 5'd0, 5'd7, 32'h0, 32'h77, 4'd0, 1'b1, 1'b0));
    step();
    chk("post_rst_issue_valid", 32'(o_valid), 1);
    i_valid = 1'b0;
    step(); step();
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
